// File: rtl/add_sum_accum.sv
// -----------------------------------------------------------------------------
// add_sum_accum
//
// Purpose:
//   Consumes the 5-bit sums produced by the 4-bit adder stage on a valid/ready
//   handshake and accumulates them into a saturating running total. A block
//   closes after BLOCK_LEN samples or early on a flush pulse. The closed
//   block's total, sample count and saturation flag are then held on an
//   output valid/ready handshake until the consumer takes them.
//
// Parameters:
//   SUM_W     - width of the incoming sum (adder output width)
//   ACC_W     - width of the accumulated total
//   BLOCK_LEN - samples per block, legal range 1..255
//
// Ports:
//   clk       in   1      clock, all logic on the rising edge
//   rst       in   1      synchronous, active-high reset
//   in_valid  in   1      in_sum is valid this cycle
//   in_ready  out  1      block can accept a sum this cycle (registered)
//   in_sum    in   SUM_W  adder result, unsigned
//   flush     in   1      close the current block early (single-cycle pulse)
//   out_valid out  1      block result available (registered)
//   out_ready in   1      downstream takes the result
//   out_total out  ACC_W  saturated block total (registered)
//   out_count out  8      number of samples in the block (registered)
//   out_ovf   out  1      total saturated at least once in the block
// -----------------------------------------------------------------------------
module add_sum_accum #(
  parameter int SUM_W     = 5,
  parameter int ACC_W     = 12,
  parameter int BLOCK_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Compared against count+1 with one spare bit so the compare never wraps.
  localparam logic [8:0] BLOCK_LEN_C = 9'(BLOCK_LEN);

  // Saturating add: returns {overflow, clamped_sum}. The raw sum of an ACC_W
  // value and a narrower value fits in ACC_W+1 bits, so its top bit alone
  // says whether the clamp value 2^ACC_W-1 was exceeded.
  function automatic logic [ACC_W:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [SUM_W-1:0] b
  );
    logic [ACC_W:0] raw;
    raw = {1'b0, a} + {{(ACC_W + 1 - SUM_W){1'b0}}, b};
    if (raw[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = raw;
    end
  endfunction

  state_e           state_q,     state_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [7:0]       count_q,     count_d;
  logic             ovf_q,       ovf_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_total_q, out_total_d;
  logic [7:0]       out_count_q, out_count_d;
  logic             out_ovf_q,   out_ovf_d;

  logic             accept_s;
  logic             close_s;
  logic [ACC_W:0]   sat_s;
  logic [8:0]       count_inc_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_total = out_total_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // Next-state, accumulation and block-close decision.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_total_d = out_total_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    accept_s    = 1'b0;
    close_s     = 1'b0;
    sat_s       = sat_add(acc_q, in_sum);
    count_inc_s = {1'b0, count_q} + 9'd1;

    case (state_q)
      ST_ACCUM: begin
        // in_ready is high for the whole ACCUM state, so the state alone
        // qualifies the accept and in_ready never depends on in_valid.
        accept_s = in_valid;

        if (accept_s) begin
          acc_d   = sat_s[ACC_W-1:0];
          count_d = count_inc_s[7:0];
          ovf_d   = ovf_q | sat_s[ACC_W];
        end else begin
          acc_d   = acc_q;
          count_d = count_q;
          ovf_d   = ovf_q;
        end

        // A flush on an empty block with nothing arriving is ignored.
        if (accept_s && (count_inc_s == BLOCK_LEN_C)) begin
          close_s = 1'b1;
        end else if (flush && ((count_q != 8'd0) || accept_s)) begin
          close_s = 1'b1;
        end else begin
          close_s = 1'b0;
        end

        if (close_s) begin
          state_d     = ST_HOLD;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_total_d = acc_d;
          out_count_d = count_d;
          out_ovf_d   = ovf_d;
        end else begin
          state_d     = ST_ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        // Result registers are left untouched so they stay stable until
        // the consumer takes them.
        if (out_ready) begin
          state_d     = ST_ACCUM;
          acc_d       = {ACC_W{1'b0}};
          count_d     = 8'd0;
          ovf_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end else begin
          state_d     = ST_HOLD;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover to an empty accumulating block.
        state_d     = ST_ACCUM;
        acc_d       = {ACC_W{1'b0}};
        count_d     = 8'd0;
        ovf_d       = 1'b0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, accumulator and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= {ACC_W{1'b0}};
      count_q     <= 8'd0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_total_q <= {ACC_W{1'b0}};
      out_count_q <= 8'd0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_total_q <= out_total_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_add_sum_accum.sv
// -----------------------------------------------------------------------------
// tb_add_sum_accum
//
// Scoreboard bench for add_sum_accum. Instance A uses default parameters
// (SUM_W=5, ACC_W=12, BLOCK_LEN=8); instance B uses ACC_W=6, BLOCK_LEN=4 to
// reach saturation. Drivers update a small block model on every accepted
// sample and push the expected block into a queue when the model closes a
// block; monitors pop and compare on each output handshake.
// -----------------------------------------------------------------------------
module tb_add_sum_accum;

  typedef struct {
    int total;
    int count;
    int ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, out_ovf_a;
  logic [4:0]  in_sum_a;
  logic [11:0] out_total_a;
  logic [7:0]  out_count_a;
  logic        man_rdy_a, rnd_rdy_a, rnd_mode;

  logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, out_ovf_b;
  logic [4:0]  in_sum_b;
  logic [5:0]  out_total_b;
  logic [7:0]  out_count_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_a, cnt_a, ovf_a;
  int   acc_b, cnt_b, ovf_b;

  assign out_ready_a = rnd_mode ? rnd_rdy_a : man_rdy_a;

  add_sum_accum u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_sum(in_sum_a), .flush(flush_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_total(out_total_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  add_sum_accum #(.SUM_W(5), .ACC_W(6), .BLOCK_LEN(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sum(in_sum_b), .flush(flush_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_total(out_total_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Present one sample and/or flush to A, hold it until taken, update the model.
  task automatic send_a(input bit v, input int s, input bit f);
    int n;
    in_valid_a = v;
    in_sum_a   = 5'(s);
    flush_a    = f;
    n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_accept_wait", in_ready_a, 1);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    flush_a    = 1'b0;
    if (v) begin
      acc_a = acc_a + s;
      if (acc_a > 4095) begin
        acc_a = 4095;
        ovf_a = 1;
      end
      cnt_a++;
    end
    if ((v && cnt_a == 8) || (f && cnt_a > 0)) begin
      q_a.push_back('{acc_a, cnt_a, ovf_a});
      acc_a = 0; cnt_a = 0; ovf_a = 0;
    end
  endtask

  // Same for B (BLOCK_LEN=4, clamp at 63).
  task automatic send_b(input int s);
    int n;
    in_valid_b = 1'b1;
    in_sum_b   = 5'(s);
    n = 0;
    @(negedge clk);
    while (!in_ready_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_accept_wait", in_ready_b, 1);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    acc_b = acc_b + s;
    if (acc_b > 63) begin
      acc_b = 63;
      ovf_b = 1;
    end
    cnt_b++;
    if (cnt_b == 4) begin
      q_b.push_back('{acc_b, cnt_b, ovf_b});
      acc_b = 0; cnt_b = 0; ovf_b = 0;
    end
  endtask

  task automatic clear_models();
    acc_a = 0; cnt_a = 0; ovf_a = 0;
    acc_b = 0; cnt_b = 0; ovf_b = 0;
    q_a.delete();
    q_b.delete();
  endtask

  // Monitor A: compare every output handshake against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid_a === 1'b1 && out_ready_a === 1'b1) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_block", 1, 0);
        end else begin
          e = q_a.pop_front();
          chk("a_total", out_total_a, e.total);
          chk("a_count", out_count_a, e.count);
          chk("a_ovf",   out_ovf_a,   e.ovf);
        end
      end
    end
  end

  // Monitor B.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid_b === 1'b1 && out_ready_b === 1'b1) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_block", 1, 0);
        end else begin
          e = q_b.pop_front();
          chk("b_total", out_total_b, e.total);
          chk("b_count", out_count_b, e.count);
          chk("b_ovf",   out_ovf_b,   e.ovf);
        end
      end
    end
  end

  // Random out_ready for A, used only while rnd_mode is set.
  initial begin
    rnd_rdy_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy_a = ($urandom_range(0, 2) != 0);
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Main directed sequence.
  initial begin
    int n;
    bit v, f;
    rst = 1'b1;
    in_valid_a = 1'b0; in_sum_a = 5'd0; flush_a = 1'b0; man_rdy_a = 1'b1; rnd_mode = 1'b0;
    in_valid_b = 1'b0; in_sum_b = 5'd0; flush_b = 1'b0; out_ready_b = 1'b1;
    clear_models();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_in_ready",  in_ready_a,  1);
    chk("rst_out_total", out_total_a, 0);
    chk("rst_out_count", out_count_a, 0);
    chk("rst_out_ovf",   out_ovf_a,   0);
    rst = 1'b0;

    // Full block: 8 x 8 back to back -> 64/8/0, in_ready low one cycle.
    for (int i = 0; i < 8; i++) send_a(1'b1, 8, 1'b0);
    chk("full_out_valid_rise", out_valid_a, 1);
    chk("full_in_ready_low",   in_ready_a,  0);
    @(posedge clk); #1;
    chk("full_in_ready_back",  in_ready_a,  1);
    chk("full_out_valid_fall", out_valid_a, 0);

    // Backpressure: result held stable for 5 cycles.
    man_rdy_a = 1'b0;
    for (int i = 0; i < 8; i++) send_a(1'b1, 8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_in_ready",  in_ready_a,  0);
      chk("bp_total",     out_total_a, 64);
      chk("bp_count",     out_count_a, 8);
      @(posedge clk); #1;
    end
    man_rdy_a = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after",  in_ready_a,  1);
    chk("bp_out_valid_after", out_valid_a, 0);

    // Early flush with the last sample: 8+7+10 -> 25/3.
    send_a(1'b1, 8, 1'b0);
    send_a(1'b1, 7, 1'b0);
    send_a(1'b1, 10, 1'b1);
    chk("flush_out_valid", out_valid_a, 1);
    @(posedge clk); #1;
    // Flush on an empty block is ignored.
    send_a(1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush_no_valid", out_valid_a, 0);
      @(posedge clk); #1;
    end

    // Saturation on B: 30,30,30,1 -> 63/4/1 ; then 1,1,1,1 -> 4/4/0.
    send_b(30); send_b(30); send_b(30); send_b(1);
    chk("sat_out_valid", out_valid_b, 1);
    send_b(1); send_b(1); send_b(1); send_b(1);
    @(posedge clk); #1;

    // Reset after 5 accepted samples discards the partial block.
    for (int i = 0; i < 5; i++) send_a(1'b1, 3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_out_valid", out_valid_a, 0);
    chk("rstmid_total",     out_total_a, 0);
    chk("rstmid_count",     out_count_a, 0);
    chk("rstmid_in_ready",  in_ready_a,  1);
    rst = 1'b0;
    clear_models();
    for (int i = 0; i < 8; i++) send_a(1'b1, 3, 1'b0);
    @(posedge clk); #1;

    // Reset during HOLD discards the pending result.
    man_rdy_a = 1'b0;
    for (int i = 0; i < 8; i++) send_a(1'b1, 3, 1'b0);
    @(posedge clk); #1;
    chk("rsthold_pending", out_valid_a, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rsthold_out_valid", out_valid_a, 0);
    chk("rsthold_total",     out_total_a, 0);
    chk("rsthold_count",     out_count_a, 0);
    chk("rsthold_ovf",       out_ovf_a,   0);
    rst = 1'b0;
    clear_models();
    man_rdy_a = 1'b1;
    for (int i = 0; i < 8; i++) send_a(1'b1, 3, 1'b0);
    @(posedge clk); #1;

    // Random gaps, flushes and out_ready.
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk); #1;
      end
      f = ($urandom_range(0, 7) == 0);
      v = f ? ($urandom_range(0, 1) == 1) : 1'b1;
      send_a(v, $urandom_range(0, 31), f);
    end
    rnd_mode = 1'b0;
    send_a(1'b0, 0, 1'b1);

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
